// File: rtl/stage_sequencer.sv
// stage_sequencer: five-stage instruction sequencer with fetch/memory
// handshakes, stall hold, halt and retired-instruction count.
// Optional macro STAGE_SKIP_EN: NOP instructions retire from stage 2.
module stage_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic               Clock,
    input  logic               Reset_L,
    input  logic               Start,
    input  logic               Stall,
    input  logic               MEM_Ready,
    input  logic               Mem_Access,
    input  logic               Halt_Req,
    input  logic               NOP_In,
    output logic [2:0]         Stage,
    output logic               NOP_FLAG,
    output logic               Running,
    output logic               Stage_Wait,
    output logic [COUNT_W-1:0] Instr_Count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S1     = 3'd1,
        S2     = 3'd2,
        S3     = 3'd3,
        S4     = 3'd4,
        S5     = 3'd5,
        HALTED = 3'd7
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               adv;
    logic               retire;
    logic               halt_pend;
    logic               nop_q;
    logic [COUNT_W-1:0] count_q;

    // State register; the stage code comes straight from here.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, advance and retirement decode.
    always_comb begin
        state_next = state;
        adv        = 1'b0;
        retire     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next = S1;
                end
            end
            S1: begin
                adv = !Stall && MEM_Ready;
                if (adv) begin
                    state_next = S2;
                end
            end
            S2: begin
                adv = !Stall;
                if (adv) begin
`ifdef STAGE_SKIP_EN
                    if (NOP_In) begin
                        retire     = 1'b1;
                        state_next = Halt_Req ? HALTED : S1;
                    end else begin
                        state_next = S3;
                    end
`else
                    state_next = S3;
`endif
                end
            end
            S3: begin
                adv = !Stall;
                if (adv) begin
                    state_next = S4;
                end
            end
            S4: begin
                adv = !Stall && (!Mem_Access || MEM_Ready);
                if (adv) begin
                    state_next = S5;
                end
            end
            S5: begin
                adv = !Stall;
                if (adv) begin
                    retire     = 1'b1;
                    state_next = halt_pend ? HALTED : S1;
                end
            end
            HALTED: begin
                if (Start) begin
                    state_next = S1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-instruction flags captured in decode and the retire counter.
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            nop_q     <= 1'b0;
            halt_pend <= 1'b0;
            count_q   <= '0;
        end else begin
            if (retire) begin
                count_q <= count_q + COUNT_W'(1);
            end
            if (state == S2 && adv) begin
                nop_q     <= NOP_In;
                halt_pend <= Halt_Req;
            end
            if (state_next == S1 && state != S1) begin
                nop_q <= 1'b0;
            end
            if (state_next == HALTED) begin
                halt_pend <= 1'b0;
            end
        end
    end

    // Status outputs; the wait flag reflects a busy stage that holds.
    always_comb begin
        Stage       = state;
        Running     = (state == S1) || (state == S2) || (state == S3) ||
                      (state == S4) || (state == S5);
        Stage_Wait  = Running && !adv;
        NOP_FLAG    = nop_q;
        Instr_Count = count_q;
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed vector bench for stage_sequencer,
// with a narrow-counter twin instance to exercise counter wrap.
module tb_stage_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        mem_ready;
    logic        mem_access;
    logic        halt_req;
    logic        nop_in;
    logic [2:0]  stage;
    logic        nop_flag;
    logic        running;
    logic        stage_wait;
    logic [15:0] count;
    logic [2:0]  stage_w;
    logic        nop_flag_w;
    logic        running_w;
    logic        stage_wait_w;
    logic [1:0]  count_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       st;
        logic       sl;
        logic       mr;
        logic       ma;
        logic       hr;
        logic       ni;
        logic       w;
        logic [2:0] stg;
        logic       nop;
        int         cnt;
    } vec_t;

    vec_t vecs[$];

    stage_sequencer #(.COUNT_W(16)) dut (
        .Clock(clk), .Reset_L(rst_n), .Start(start), .Stall(stall),
        .MEM_Ready(mem_ready), .Mem_Access(mem_access),
        .Halt_Req(halt_req), .NOP_In(nop_in), .Stage(stage),
        .NOP_FLAG(nop_flag), .Running(running), .Stage_Wait(stage_wait),
        .Instr_Count(count)
    );

    stage_sequencer #(.COUNT_W(2)) dut_w (
        .Clock(clk), .Reset_L(rst_n), .Start(start), .Stall(stall),
        .MEM_Ready(mem_ready), .Mem_Access(mem_access),
        .Halt_Req(halt_req), .NOP_In(nop_in), .Stage(stage_w),
        .NOP_FLAG(nop_flag_w), .Running(running_w),
        .Stage_Wait(stage_wait_w), .Instr_Count(count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, sl, mr, ma, hr, ni,
                                input logic w, input logic [2:0] stg,
                                input logic nop, input int cnt);
        vec_t v;
        v.st = st; v.sl = sl; v.mr = mr; v.ma = ma; v.hr = hr; v.ni = ni;
        v.w = w; v.stg = stg; v.nop = nop; v.cnt = cnt;
        return v;
    endfunction

    task automatic v(input logic st, sl, mr, ma, hr, ni,
                     input logic w, input logic [2:0] stg,
                     input logic nop, input int cnt);
        vecs.push_back(mk(st, sl, mr, ma, hr, ni, w, stg, nop, cnt));
    endtask

    task automatic apply(input vec_t x, input string tag);
        int run_exp;
        @(negedge clk);
        start = x.st; stall = x.sl; mem_ready = x.mr;
        mem_access = x.ma; halt_req = x.hr; nop_in = x.ni;
        #1;
        check({tag, "_wait"}, int'(stage_wait), int'(x.w));
        check({tag, "_wait_w"}, int'(stage_wait_w), int'(x.w));
        @(posedge clk);
        #1;
        run_exp = (x.stg >= 3'd1 && x.stg <= 3'd5) ? 1 : 0;
        check({tag, "_stage"}, int'(stage), int'(x.stg));
        check({tag, "_running"}, int'(running), run_exp);
        check({tag, "_nop"}, int'(nop_flag), int'(x.nop));
        check({tag, "_count"}, int'(count), x.cnt);
        check({tag, "_count_w"}, int'(count_w), x.cnt % 4);
    endtask

    task automatic idle_inputs();
        start = 0; stall = 0; mem_ready = 0;
        mem_access = 0; halt_req = 0; nop_in = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // three back-to-back instructions, ignored inputs in instr 2
        v(1,0,1,0,0,0, 0,3'd1,0,0);
        v(0,0,1,0,0,0, 0,3'd2,0,0);
        v(0,0,1,0,0,0, 0,3'd3,0,0);
        v(0,0,1,0,0,0, 0,3'd4,0,0);
        v(0,0,1,0,0,0, 0,3'd5,0,0);
        v(0,0,1,0,0,0, 0,3'd1,0,1);
        v(0,0,1,0,0,0, 0,3'd2,0,1);
        v(1,0,1,0,0,0, 0,3'd3,0,1);
        v(0,0,1,0,1,0, 0,3'd4,0,1);
        v(0,0,1,0,0,1, 0,3'd5,0,1);
        v(0,0,1,0,0,0, 0,3'd1,0,2);
        v(0,0,1,0,0,0, 0,3'd2,0,2);
        v(0,0,1,0,0,0, 0,3'd3,0,2);
        v(0,0,1,0,0,0, 0,3'd4,0,2);
        v(0,0,1,0,0,0, 0,3'd5,0,2);
        v(0,0,1,0,0,0, 0,3'd1,0,3);
        // fetch wait x3, then memory wait x2 in S4
        v(0,0,0,0,0,0, 1,3'd1,0,3);
        v(0,0,0,0,0,0, 1,3'd1,0,3);
        v(0,0,0,0,0,0, 1,3'd1,0,3);
        v(0,0,1,0,0,0, 0,3'd2,0,3);
        v(0,0,1,0,0,0, 0,3'd3,0,3);
        v(0,0,1,1,0,0, 0,3'd4,0,3);
        v(0,0,0,1,0,0, 1,3'd4,0,3);
        v(0,0,0,1,0,0, 1,3'd4,0,3);
        v(0,0,1,1,0,0, 0,3'd5,0,3);
        v(0,0,0,0,0,0, 0,3'd1,0,4);
        // stall priority over MEM_Ready
        v(0,0,1,0,0,0, 0,3'd2,0,4);
        v(1,1,1,0,0,0, 1,3'd2,0,4);
        v(0,0,1,0,0,0, 0,3'd3,0,4);
        v(0,0,1,0,0,0, 0,3'd4,0,4);
        v(0,1,1,1,0,0, 1,3'd4,0,4);
        v(0,1,1,0,0,0, 1,3'd4,0,4);
        v(0,0,0,0,0,0, 0,3'd5,0,4);
        v(0,1,1,0,0,0, 1,3'd5,0,4);
        v(0,0,1,0,0,0, 0,3'd1,0,5);
        // halt requested in decode
        v(0,0,1,0,0,0, 0,3'd2,0,5);
        v(0,0,1,0,1,0, 0,3'd3,0,5);
        v(0,0,1,0,0,0, 0,3'd4,0,5);
        v(0,0,1,0,0,0, 0,3'd5,0,5);
        v(0,0,1,0,0,0, 0,3'd7,0,6);
        v(0,0,1,0,0,0, 0,3'd7,0,6);
        v(1,0,1,0,0,0, 0,3'd1,0,6);
        // halt/nop outside decode ignored, stall in fetch
        v(0,1,1,0,1,1, 1,3'd1,0,6);
        v(0,0,1,0,1,0, 0,3'd2,0,6);
        v(0,0,1,0,0,0, 0,3'd3,0,6);
        v(0,0,1,0,1,1, 0,3'd4,0,6);
        v(0,0,1,0,1,0, 0,3'd5,0,6);
        v(0,0,1,0,1,0, 0,3'd1,0,7);

        #12;
        check("rst_stage", int'(stage), 0);
        check("rst_count", int'(count), 0);
        check("rst_running", int'(running), 0);
        check("rst_wait", int'(stage_wait), 0);
        check("rst_nop", int'(nop_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_hold", int'(stage), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

`ifdef STAGE_SKIP_EN
        apply(mk(0,0,1,0,0,0, 0,3'd2,0,7), "skip_a");
        apply(mk(0,0,1,0,0,1, 0,3'd1,0,8), "skip_b");
        apply(mk(0,0,1,0,0,0, 0,3'd2,0,8), "skip_c");
        apply(mk(0,0,1,0,1,1, 0,3'd7,1,9), "skip_d");
        apply(mk(1,0,1,0,0,0, 0,3'd1,0,9), "skip_e");
`else
        apply(mk(0,0,1,0,0,0, 0,3'd2,0,7), "nop_a");
        apply(mk(0,0,1,0,0,1, 0,3'd3,1,7), "nop_b");
        apply(mk(0,0,1,0,0,0, 0,3'd4,1,7), "nop_c");
        apply(mk(0,0,1,0,0,0, 0,3'd5,1,7), "nop_d");
        apply(mk(0,0,1,0,0,0, 0,3'd1,0,8), "nop_e");
`endif

        // asynchronous reset in the middle of S3
        apply(mk(0,0,1,0,0,0, 0,3'd2,0,
`ifdef STAGE_SKIP_EN
                 9
`else
                 8
`endif
                 ), "ar_a");
        @(negedge clk);
        @(posedge clk);
        #3;
        check("ar_pre_stage", int'(stage), 3);
        rst_n = 1'b0;
        #1;
        check("ar_stage", int'(stage), 0);
        check("ar_count", int'(count), 0);
        check("ar_count_w", int'(count_w), 0);
        check("ar_running", int'(running), 0);
        check("ar_wait", int'(stage_wait), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        apply(mk(1,0,1,0,0,0, 0,3'd1,0,0), "ar_restart");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter: COUNT_W, 16, width of the retired-instruction counter.
REQ-002 The block SHALL use a single clock and an asynchronous, active-low reset.
REQ-003 Port: Clock  input  1  rising-edge clock for all state.
REQ-004 Port: Reset_L  input  1  asynchronous active-low reset.
REQ-005 Port: Start  input  1  begin sequencing from IDLE or HALTED.
REQ-006 Port: Stall  input  1  external hold; freezes the current stage.
REQ-007 Port: MEM_Ready  input  1  memory handshake; high when the requested access completes this cycle.
REQ-008 Port: Mem_Access  input  1  current instruction uses memory in stage 4 (load or store).
REQ-009 Port: Halt_Req  input  1  decoded halt opcode, sampled in stage 2.
REQ-010 Port: NOP_In  input  1  decoded NOP indication, sampled in stage 2.
REQ-011 Port: Stage  output  3  stage code: 0 IDLE, 1 Fetch, 2 Decode, 3 Execute, 4 Memory, 5 Write Back, 7 HALTED.
REQ-012 Port: NOP_FLAG  output  1  registered NOP indication for the current instruction.
REQ-013 Port: Running  output  1  high in stages 1-5.
REQ-014 Port: Stage_Wait  output  1  high in any cycle where Stage is held by Stall or MEM_Ready.
REQ-015 Port: Instr_Count  output  COUNT_W  number of retired instructions.

Function
REQ-016 FSM states SHALL be IDLE, S1..S5 and HALTED; Stage SHALL be driven directly from the state register, with no combinational path from inputs.
REQ-017 IDLE SHALL go to S1 on the edge where Start=1; otherwise it SHALL hold.
REQ-018 The normal progression SHALL be S1->S2->S3->S4->S5->S1, one stage per cycle when not held.
REQ-019 S1 SHALL hold until MEM_Ready=1 (instruction fetch).
REQ-020 S4 SHALL hold until MEM_Ready=1 when Mem_Access=1; when Mem_Access=0, S4 SHALL advance unconditionally.
REQ-021 Stall=1 SHALL hold any of S1-S5 and SHALL take priority over MEM_Ready.
REQ-022 Stage_Wait SHALL be combinationally 1 exactly when the current S1-S5 state will not advance at the next edge.
REQ-023 In S2 while advancing, the block SHALL latch NOP_In into NOP_FLAG and latch Halt_Req into an internal halt-pending bit.
REQ-024 NOP_FLAG SHALL clear on entry to S1.
REQ-025 On exit from S5, the next state SHALL be HALTED if halt-pending=1, else S1; halt-pending SHALL clear on entry to HALTED.
REQ-026 Instr_Count SHALL increment by 1 on every instruction retirement: exit from S5, plus any skip exit from REQ-033.
REQ-027 Instr_Count SHALL wrap from all-ones to 0.
REQ-028 HALTED SHALL go to S1 on Start=1, with Instr_Count retained.
REQ-029 Start SHALL be ignored in S1-S5.
REQ-030 Halt_Req and NOP_In SHALL be ignored outside S2.
REQ-031 Running SHALL equal 1 exactly in S1-S5.

Reset
REQ-032 While Reset_L=0, asynchronously and mid-operation included: state=IDLE, Stage=0, NOP_FLAG=0, Running=0, Stage_Wait=0, Instr_Count=0, halt-pending=0.

Configuration
REQ-033 With STAGE_SKIP_EN defined, an instruction with NOP_In=1 latched in S2 SHALL go S2->S1 (skipping S3-S5), count as retired on that edge, and honour Halt_Req (S2->HALTED if both are set).
REQ-034 Without STAGE_SKIP_EN, every instruction SHALL traverse S1-S5, including NOPs.

Verification
REQ-035 Reset_L=0 asserted mid-S3 -> Stage=0, Instr_Count=0 immediately, without waiting for a clock edge.
REQ-036 Start=1 for one cycle; MEM_Ready=1; Mem_Access=0; 3 instructions -> Stage sequence 1,2,3,4,5 repeated; Instr_Count=3 after 15 cycles.
REQ-037 MEM_Ready=0 for 3 cycles in S1, then Mem_Access=1 with MEM_Ready=0 for 2 cycles in S4 -> Stage holds with Stage_Wait=1 for those cycles; the instruction retires at cycle 10.
REQ-038 Stall=1 and MEM_Ready=1 together in S4 -> hold; Stage advances to 5 one cycle after Stall drops.
REQ-039 Halt_Req=1 in S2 -> stages 3,4,5 complete, then Stage=7 and Running=0; Start=1 -> Stage=1 with Instr_Count retained.
REQ-040 STAGE_SKIP_EN defined, NOP_In=1 in S2 -> next Stage=1, Instr_Count+1; without the macro -> stages 3,4,5 run with NOP_FLAG=1.
